// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive-side controller.
package uart_pkg;

    // Character-timeout timer states.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        EXPIRED = 2'd2
    } rx_tmr_state_e;

    // Interrupt status / enable bit positions.
    localparam int IRQ_THR = 0;
    localparam int IRQ_TO  = 1;
    localparam int IRQ_OVF = 2;
    localparam int IRQ_W   = 3;

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous byte FIFO with registered read port, flush and occupancy.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module uart_rx_fifo #(
    parameter int DEPTH = 16,
    parameter int LW    = $clog2(DEPTH) + 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          push,
    input  logic [7:0]    wr_data,
    input  logic          pop,
    input  logic          clr,
    output logic [7:0]    rd_data,
    output logic          rd_valid,
    output logic          full,
    output logic          empty,
    output logic [LW-1:0] level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [LW-1:0] level_reg;
    logic [7:0]    rd_data_reg;
    logic          rd_valid_reg;
    logic          pop_ok;
    logic          push_ok;

    assign full    = (level_reg == FULL_LVL);
    assign empty   = (level_reg == '0);
    // Flush wins over both ports; a pop frees the slot a full-FIFO push needs.
    assign pop_ok  = pop && !clr && !empty;
    assign push_ok = push && !clr && (!full || pop_ok);

    // Storage array: no reset so it maps onto block RAM.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    // Pointers, occupancy and the registered read port.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            level_reg    <= '0;
            rd_data_reg  <= '0;
            rd_valid_reg <= 1'b0;
        end else if (clr) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            level_reg    <= '0;
            rd_valid_reg <= 1'b0;
        end else begin
            rd_valid_reg <= pop_ok;
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_reg  <= rd_ptr_reg + 1'b1;
                rd_data_reg <= mem[rd_ptr_reg];
            end
            case ({push_ok, pop_ok})
                2'b10:   level_reg <= level_reg + 1'b1;
                2'b01:   level_reg <= level_reg - 1'b1;
                default: level_reg <= level_reg;
            endcase
        end
    end

    assign rd_data  = rd_data_reg;
    assign rd_valid = rd_valid_reg;
    assign level    = level_reg;

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: byte FIFO, character-timeout timer and
// maskable sticky interrupts for threshold, timeout and overflow.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter  int DEPTH   = 16,
    parameter  int TO_BITS = 40,
    localparam int LW      = $clog2(DEPTH) + 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [15:0]   baud_i,
    input  logic          rx_done_i,
    input  logic [7:0]    rx_data_i,
    input  logic          rx_start_i,
    input  logic          rd_req_i,
    output logic [7:0]    rd_data_o,
    output logic          rd_valid_o,
    input  logic          fifo_clr_i,
    input  logic [LW-1:0] thresh_i,
    output logic [LW-1:0] level_o,
    input  logic [2:0]    irq_en_i,
    input  logic [2:0]    irq_clr_i,
    output logic [2:0]    irq_status_o,
    output logic          irq_o
);

    localparam logic [7:0] LAST_BIT = 8'(TO_BITS - 1);

    logic          fifo_full;
    logic          fifo_empty;
    logic [LW-1:0] fifo_level;
    logic          pop_acc;

    rx_tmr_state_e state_reg, state_next;
    logic [15:0]   clk_cnt_reg, clk_cnt_next;
    logic [7:0]    bit_cnt_reg, bit_cnt_next;
    logic          clk_wrap;
    logic          to_set;
    logic [2:0]    status_reg, status_next;
    logic [2:0]    status_set;

    uart_rx_fifo #(
        .DEPTH (DEPTH),
        .LW    (LW)
    ) u_fifo (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .push     (rx_done_i),
        .wr_data  (rx_data_i),
        .pop      (rd_req_i),
        .clr      (fifo_clr_i),
        .rd_data  (rd_data_o),
        .rd_valid (rd_valid_o),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .level    (fifo_level)
    );

    assign level_o  = fifo_level;
    assign pop_acc  = rd_req_i && !fifo_empty && !fifo_clr_i;
    // >= rather than == so a lowered baud_i mid-count still wraps promptly.
    assign clk_wrap = (clk_cnt_reg >= (baud_i - 16'd1));

    // Timer state and bit-period counters.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg   <= IDLE;
            clk_cnt_reg <= '0;
            bit_cnt_reg <= '0;
        end else begin
            state_reg   <= state_next;
            clk_cnt_reg <= clk_cnt_next;
            bit_cnt_reg <= bit_cnt_next;
        end
    end

    // Timer next state; counters fall back to zero unless ARMED keeps counting.
    always_comb begin
        state_next   = state_reg;
        clk_cnt_next = '0;
        bit_cnt_next = '0;
        to_set       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!fifo_clr_i && rx_done_i && (baud_i != 16'd0)) begin
                    state_next = ARMED;
                end
            end
            ARMED: begin
                if (fifo_clr_i || rx_start_i || (baud_i == 16'd0)) begin
                    state_next = IDLE;
                end else if (rx_done_i || pop_acc) begin
                    state_next = ARMED;
                end else if (fifo_empty) begin
                    state_next = IDLE;
                end else if (clk_wrap) begin
                    if (bit_cnt_reg == LAST_BIT) begin
                        state_next = EXPIRED;
                        to_set     = 1'b1;
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 8'd1;
                    end
                end else begin
                    clk_cnt_next = clk_cnt_reg + 16'd1;
                    bit_cnt_next = bit_cnt_reg;
                end
            end
            EXPIRED: begin
                if (fifo_clr_i || (baud_i == 16'd0)) begin
                    state_next = IDLE;
                end else if (rx_done_i) begin
                    state_next = ARMED;
                end else if (fifo_empty) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Status set sources; setting takes priority over a same-cycle clear.
    always_comb begin
        status_set          = '0;
        status_set[IRQ_THR] = (thresh_i != '0) && (fifo_level >= thresh_i);
        status_set[IRQ_TO]  = to_set;
        status_set[IRQ_OVF] = rx_done_i && !fifo_clr_i && fifo_full && !pop_acc;
        status_next         = (status_reg & ~irq_clr_i) | status_set;
    end

    // Sticky interrupt status register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            status_reg <= '0;
        end else begin
            status_reg <= status_next;
        end
    end

    assign irq_status_o = status_reg;
    assign irq_o        = |(status_reg & irq_en_i);

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: directed scenarios plus randomized traffic, checked
// against a queue-based FIFO model and a deadline-based timeout model.
module tb_uart_rx_ctrl;

    localparam int DEPTH   = 16;
    localparam int TO_BITS = 40;
    localparam int LW      = $clog2(DEPTH) + 1;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic [15:0]   baud_i;
    logic          rx_done_i;
    logic [7:0]    rx_data_i;
    logic          rx_start_i;
    logic          rd_req_i;
    logic [7:0]    rd_data_o;
    logic          rd_valid_o;
    logic          fifo_clr_i;
    logic [LW-1:0] thresh_i;
    logic [LW-1:0] level_o;
    logic [2:0]    irq_en_i;
    logic [2:0]    irq_clr_i;
    logic [2:0]    irq_status_o;
    logic          irq_o;

    always #5 clk_i = ~clk_i;

    uart_rx_ctrl #(
        .DEPTH   (DEPTH),
        .TO_BITS (TO_BITS)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .baud_i       (baud_i),
        .rx_done_i    (rx_done_i),
        .rx_data_i    (rx_data_i),
        .rx_start_i   (rx_start_i),
        .rd_req_i     (rd_req_i),
        .rd_data_o    (rd_data_o),
        .rd_valid_o   (rd_valid_o),
        .fifo_clr_i   (fifo_clr_i),
        .thresh_i     (thresh_i),
        .level_o      (level_o),
        .irq_en_i     (irq_en_i),
        .irq_clr_i    (irq_clr_i),
        .irq_status_o (irq_status_o),
        .irq_o        (irq_o)
    );

    int total = 0;
    int bad   = 0;

    // Reference model state.
    logic [7:0] model_q[$];    // bytes held in the FIFO
    logic [7:0] exp_q[$];      // scoreboard: bytes expected on the read port
    int         t_mode;        // 0 idle, 1 counting, 2 expired
    longint     cyc;           // edge counter
    longint     deadline;      // edge at which an uninterrupted count expires
    logic [2:0] m_status;
    logic       m_rd_valid;
    logic [7:0] mon_exp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s at %0t: got %0h required %0h", name, $time, act, req);
        end
    endtask

    // Monitor: every read strobe must match the oldest expected byte.
    always @(negedge clk_i) begin
        if (rst_i === 1'b0 && rd_valid_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL rd_unexpected at %0t: got %0h required no read", $time, rd_data_o);
            end else begin
                mon_exp = exp_q.pop_front();
                check("rd_data", {24'd0, rd_data_o}, {24'd0, mon_exp});
            end
        end
    end

    task automatic model_reset();
        model_q.delete();
        exp_q.delete();
        t_mode     = 0;
        deadline   = 0;
        m_status   = '0;
        m_rd_valid = 1'b0;
    endtask

    // One clock edge of the behavioural model, from the rules of operation.
    task automatic model_edge(input logic done, input logic [7:0] data, input logic start,
                              input logic rd, input logic clr, input logic [2:0] iclr);
        int         lvl;
        logic       pop_ok;
        logic       push_ok;
        logic [2:0] set;
        cyc++;
        lvl = model_q.size();
        set = '0;
        if (thresh_i != 0 && lvl >= int'(thresh_i)) set[0] = 1'b1;
        pop_ok  = rd && lvl > 0 && !clr;
        push_ok = done && !clr && (lvl < DEPTH || pop_ok);
        if (done && !clr && lvl == DEPTH && !pop_ok) set[2] = 1'b1;
        case (t_mode)
            0: if (!clr && done && baud_i != 0) begin
                t_mode = 1; deadline = cyc + longint'(TO_BITS) * longint'(baud_i);
            end
            1: begin
                if (clr || start || baud_i == 0) t_mode = 0;
                else if (done || pop_ok) deadline = cyc + longint'(TO_BITS) * longint'(baud_i);
                else if (lvl == 0) t_mode = 0;
                else if (cyc == deadline) begin t_mode = 2; set[1] = 1'b1; end
            end
            default: begin
                if (clr || baud_i == 0) t_mode = 0;
                else if (done) begin
                    t_mode = 1; deadline = cyc + longint'(TO_BITS) * longint'(baud_i);
                end else if (lvl == 0) t_mode = 0;
            end
        endcase
        if (clr) begin
            model_q.delete();
        end else begin
            if (pop_ok) exp_q.push_back(model_q.pop_front());
            if (push_ok) model_q.push_back(data);
        end
        m_rd_valid = pop_ok;
        m_status   = (m_status & ~iclr) | set;
    endtask

    // Drive one cycle of inputs, advance model, compare registered outputs.
    task automatic step(input logic done, input logic [7:0] data, input logic start,
                        input logic rd, input logic clr, input logic [2:0] iclr);
        rx_done_i  = done;
        rx_data_i  = data;
        rx_start_i = start;
        rd_req_i   = rd;
        fifo_clr_i = clr;
        irq_clr_i  = iclr;
        @(posedge clk_i);
        #1;
        model_edge(done, data, start, rd, clr, iclr);
        check("level", {27'd0, level_o}, model_q.size());
        check("status", {29'd0, irq_status_o}, {29'd0, m_status});
        check("irq", {31'd0, irq_o}, {31'd0, |(m_status & irq_en_i)});
        check("rd_valid", {31'd0, rd_valid_o}, {31'd0, m_rd_valid});
        @(negedge clk_i);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 3'b000);
    endtask

    task automatic push(input logic [7:0] d);
        step(1'b1, d, 1'b0, 1'b0, 1'b0, 3'b000);
    endtask

    task automatic pop();
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 3'b000);
    endtask

    // Run idle cycles until timeout status appears; returns count or -1.
    task automatic wait_timeout(input int limit, output int n);
        n = -1;
        for (int i = 1; i <= limit; i++) begin
            idle(1);
            if (irq_status_o[1] === 1'b1 && n < 0) n = i;
        end
    endtask

    function automatic logic chance(input int pct);
        return $urandom_range(0, 99) < pct;
    endfunction

    int n;
    int pd, pr;

    initial begin
        rst_i      = 1'b1;
        baud_i     = 16'd4;
        rx_done_i  = 1'b0;
        rx_data_i  = 8'h00;
        rx_start_i = 1'b0;
        rd_req_i   = 1'b0;
        fifo_clr_i = 1'b0;
        thresh_i   = '0;
        irq_en_i   = 3'b000;
        irq_clr_i  = 3'b000;
        cyc        = 0;
        model_reset();
        repeat (2) @(negedge clk_i);
        check("rst_level", {27'd0, level_o}, 0);
        check("rst_rd_valid", {31'd0, rd_valid_o}, 0);
        check("rst_rd_data", {24'd0, rd_data_o}, 0);
        check("rst_status", {29'd0, irq_status_o}, 0);
        check("rst_irq", {31'd0, irq_o}, 0);
        rst_i = 1'b0;

        // Basic ordering: two bytes in, two out.
        push(8'hA5);
        push(8'h3C);
        pop();
        pop();
        idle(2);

        // Overflow: 17 pushes into a 16-deep FIFO, then drain.
        irq_en_i = 3'b100;
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 3'b111);
        for (int i = 0; i < DEPTH + 1; i++) push(8'(8'h10 + i));
        check("ovf_level", {27'd0, level_o}, DEPTH);
        check("ovf_status", {31'd0, irq_status_o[2]}, 1);
        check("ovf_irq", {31'd0, irq_o}, 1);
        for (int i = 0; i < DEPTH; i++) pop();
        idle(2);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 3'b111);

        // Timeout latency from a single push.
        irq_en_i = 3'b010;
        push(8'h55);
        wait_timeout(200, n);
        check("to_latency_push", n, 160);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 3'b111);
        idle(60);
        pop();
        idle(2);

        // Timeout restarted by a pop around cycle 100.
        push(8'h61);
        push(8'h62);
        idle(98);
        pop();
        wait_timeout(220, n);
        check("to_latency_pop", n, 160);
        pop();
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 3'b111);

        // Start bit cancels the timer for good.
        push(8'h77);
        idle(49);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 3'b000);
        idle(300);
        check("start_no_to", {31'd0, irq_status_o[1]}, 0);
        pop();
        idle(1);

        // Threshold bit persists through a clear while its condition holds.
        thresh_i = 5'd4;
        irq_en_i = 3'b001;
        for (int i = 0; i < 4; i++) push(8'(8'hC0 + i));
        idle(1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 3'b001);
        check("thr_held", {31'd0, irq_status_o[0]}, 1);
        pop();
        idle(1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 3'b001);
        check("thr_cleared", {31'd0, irq_status_o[0]}, 0);
        thresh_i = '0;
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 3'b111);

        // Full FIFO with simultaneous push and pop.
        irq_en_i = 3'b111;
        for (int i = 0; i < DEPTH; i++) push(8'(8'h80 + i));
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 3'b111);
        step(1'b1, 8'hEE, 1'b0, 1'b1, 1'b0, 3'b000);
        check("full_pp_level", {27'd0, level_o}, DEPTH);
        check("full_pp_no_ovf", {31'd0, irq_status_o[2]}, 0);
        idle(80);

        // Asynchronous reset in the middle of a timeout count.
        rx_done_i = 1'b0; rd_req_i = 1'b0; fifo_clr_i = 1'b0;
        rx_start_i = 1'b0; irq_clr_i = 3'b000;
        #2 rst_i = 1'b1;
        #1;
        check("arst_level", {27'd0, level_o}, 0);
        check("arst_rd_valid", {31'd0, rd_valid_o}, 0);
        check("arst_rd_data", {24'd0, rd_data_o}, 0);
        check("arst_status", {29'd0, irq_status_o}, 0);
        check("arst_irq", {31'd0, irq_o}, 0);
        model_reset();
        @(negedge clk_i);
        rst_i = 1'b0;

        // Randomized phases: busy and quiet traffic, varying baud/threshold/enables.
        for (int p = 0; p < 6; p++) begin
            step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 3'b000);
            baud_i   = (p % 3 == 2) ? 16'd0 : 16'($urandom_range(1, 3));
            thresh_i = LW'($urandom_range(0, DEPTH));
            irq_en_i = 3'($urandom_range(0, 7));
            pd = (p % 2 == 0) ? 30 : 2;
            pr = (p % 2 == 0) ? 25 : 1;
            for (int i = 0; i < 600; i++) begin
                step(chance(pd), 8'($urandom_range(0, 255)), chance(2), chance(pr), chance(1),
                     chance(5) ? 3'($urandom_range(1, 7)) : 3'b000);
            end
        end
        idle(2);
        check("scoreboard_drain", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

Receive-side controller for the UART: buffers received bytes from the receiver in a FIFO, sequences the character-timeout timer, and raises maskable interrupts for threshold, timeout and overflow. Sits between the UART receiver (byte strobe, start-bit detect) and the register/bus interface.

## Interface
- `DEPTH`, 16: FIFO depth in bytes, power of two, ≥2.
- `TO_BITS`, 40: timeout length in bit periods (4 character times), 1..255.
- `LW`, $clog2(DEPTH)+1: level width (derived, not overridden).

- `clk_i`  in  1  clock.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `baud_i`  in  16  clocks per bit period; 0 disables the timer.
- `rx_done_i`  in  1  one-cycle strobe: byte complete.
- `rx_data_i`  in  8  received byte, valid with `rx_done_i`.
- `rx_start_i`  in  1  start bit detected on line.
- `rd_req_i`  in  1  host pop request.
- `rd_data_o`  out  8  popped byte.
- `rd_valid_o`  out  1  `rd_data_o` valid, one cycle.
- `fifo_clr_i`  in  1  flush FIFO.
- `thresh_i`  in  LW  threshold level; 0 disables the threshold status.
- `level_o`  out  LW  current FIFO occupancy.
- `irq_en_i`  in  3  enable mask: [0] threshold, [1] timeout, [2] overflow.
- `irq_clr_i`  in  3  write-1-to-clear status strobes.
- `irq_status_o`  out  3  sticky status, same bit order.
- `irq_o`  out  1  |(irq_status_o & irq_en_i).

Reset values: `rd_data_o`=0, `rd_valid_o`=0, `level_o`=0, `irq_status_o`=0, `irq_o`=0, timer IDLE, counters 0.

## Operation
- Push: `rx_done_i` high writes `rx_data_i`. If full and no pop in the same cycle, drop the byte and set overflow status.
- Pop: `rd_req_i` high with level>0 pops one byte. Pop on empty is ignored: no `rd_valid_o`, no status change.
- Simultaneous push and pop: both succeed, including when full. Level is unchanged.
- `fifo_clr_i`: level→0, pointers→0, timer→IDLE. Overrides a same-cycle push/pop. Status bits are untouched.
- Threshold status: set every cycle that `thresh_i`≠0 and level≥`thresh_i`.
- Status bits: set wins over a same-cycle `irq_clr_i`. The threshold bit re-sets while its condition persists.
- Timer counters:
  - `clk_cnt` (16b) wraps when `clk_cnt`≥`baud_i`−1. The ≥ compare keeps a mid-count `baud_i` decrease safe.
  - Each wrap increments `bit_cnt` (8b).
- Timer FSM:
  - IDLE: on `rx_done_i` with `baud_i`≠0 → ARMED, counters 0.
  - ARMED:
    - Counters restart to 0 and stay ARMED on `rx_done_i` or an accepted pop.
    - `rx_start_i` → IDLE.
    - `baud_i`=0 or level=0 → IDLE.
    - At the wrap where `bit_cnt`=TO_BITS−1 → EXPIRED and set timeout status.
  - EXPIRED:
    - `rx_done_i` → ARMED with counters 0.
    - level=0, `fifo_clr_i` or `baud_i`=0 → IDLE.
    - Timeout status is raised once per expiry; the FSM does not re-arm by itself.
- Priority in ARMED: `fifo_clr_i` > `rx_start_i` > `rx_done_i`/pop restart > expiry.

## Timing
- Push visible in `level_o` one edge after `rx_done_i`.
- Pop: `rd_valid_o` and `rd_data_o` are registered and valid the cycle after `rd_req_i`. `level_o` decrements on the same edge.
- Timeout latency: `rx_done_i` sampled at edge 0 gives timeout status high after edge TO_BITS·`baud_i`, provided no restart occurs.
- Status and `irq_o` assert the edge after the cause; `irq_o` is combinational from registered status and enables.
- Reset is asynchronous mid-operation: all state returns to reset values immediately, and buffered data is lost.

## Structure
- Package `uart_pkg`:
  - `rx_tmr_state_e` {IDLE, ARMED, EXPIRED}.
  - Interrupt bit indices `IRQ_THR`=0, `IRQ_TO`=1, `IRQ_OVF`=2.
- Sub-module `uart_rx_fifo`: synchronous FIFO (DEPTH×8) with push, pop, clr, full, empty and level.
- The timer FSM and the interrupt logic live in `uart_rx_ctrl`.

## Test plan
- Push 0xA5, 0x3C, then pop twice. Required: `rd_data_o`=0xA5 then 0x3C, each with a one-cycle `rd_valid_o`; `level_o` goes 1,2,1,0.
- DEPTH=16: push 17 bytes with no pop. Required: level=16, overflow status=1, `irq_o`=1 with `irq_en_i`=3'b100. Byte 17 is absent on readback.
- `baud_i`=4, TO_BITS=40: one push, then idle. Required: timeout status rises exactly 160 cycles after `rx_done_i` and stays single-shot. A pop at cycle 100 instead gives no timeout until 160 cycles after the pop.
- `rx_start_i` at cycle 50 after a push, with no following `rx_done_i`. Required: timer IDLE, no timeout status ever.
- `thresh_i`=4: push 4 bytes, pulse `irq_clr_i`[0]. Required: the bit stays set. Pop 1 byte, then clear. Required: the bit clears.
- Full FIFO with push and pop in the same cycle. Required: level stays 16, no overflow. Assert `rst_i` mid-timeout. Required: all outputs 0 immediately.
